// File: rtl/hit_judge.sv
// Whack-a-mole hit judge: debounces hole buttons, arms one mole at a time and
// emits single-cycle increment/decrement/mole_done pulses. Optional macro: MISS_PENALTY_EN.
module hit_judge #(
    parameter int NUM_HOLES       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MOLE_TIMEOUT    = 50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HOLES-1:0] btn,
    input  logic                 mole_valid,
    input  logic [NUM_HOLES-1:0] mole,
    output logic                 mole_ready,
    output logic [NUM_HOLES-1:0] mole_up,
    output logic                 increment,
    output logic                 decrement,
    output logic                 mole_done
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW  = $clog2(MOLE_TIMEOUT);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  T_LAST  = TW'(MOLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COOLDOWN
    } state_t;

    logic [NUM_HOLES-1:0]          sync1_q, sync2_q;
    logic [NUM_HOLES-1:0]          deb_q, deb_d;
    logic [NUM_HOLES-1:0]          press_q;
    logic [NUM_HOLES-1:0][DBW-1:0] cnt_q, cnt_d;

    state_t               state_q;
    logic [NUM_HOLES-1:0] mole_up_q;
    logic [TW-1:0]        timer_q;
    logic                 mole_ready_q;
    logic                 increment_q, decrement_q, mole_done_q;

    logic wrong_press, right_press, timeout, mole_onehot;

    // A level change commits only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int unsigned i = 0; i < NUM_HOLES; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            press_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            // Edge taken from deb_d so the press registers in the same cycle deb_q flips.
            press_q <= deb_d & ~deb_q;
        end
    end

    assign wrong_press = |(press_q & ~mole_up_q);
    assign right_press = |(press_q & mole_up_q);
    assign timeout     = (timer_q == T_LAST);
    assign mole_onehot = (mole != '0) && ((mole & (mole - 1'b1)) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mole_up_q    <= '0;
            timer_q      <= '0;
            mole_ready_q <= 1'b1;
            increment_q  <= 1'b0;
            decrement_q  <= 1'b0;
            mole_done_q  <= 1'b0;
        end else begin
            increment_q <= 1'b0;
            decrement_q <= 1'b0;
            mole_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mole_valid && mole_ready_q && mole_onehot) begin
                        mole_up_q    <= mole;
                        timer_q      <= '0;
                        mole_ready_q <= 1'b0;
                        state_q      <= ARMED;
                    end
                end
                ARMED: begin
                    if (wrong_press) begin
                        decrement_q <= 1'b1;
                        mole_done_q <= 1'b1;
                        mole_up_q   <= '0;
                        state_q     <= COOLDOWN;
                    end else if (right_press) begin
                        increment_q <= 1'b1;
                        mole_done_q <= 1'b1;
                        mole_up_q   <= '0;
                        state_q     <= COOLDOWN;
                    end else if (timeout) begin
`ifdef MISS_PENALTY_EN
                        decrement_q <= 1'b1;
`endif
                        mole_done_q <= 1'b1;
                        mole_up_q   <= '0;
                        state_q     <= COOLDOWN;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (deb_q == '0) begin
                        mole_ready_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    mole_up_q    <= '0;
                    mole_ready_q <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign mole_ready = mole_ready_q;
    assign mole_up    = mole_up_q;
    assign increment  = increment_q;
    assign decrement  = decrement_q;
    assign mole_done  = mole_done_q;

endmodule
